// File: rtl/dca_matrix_register_banked_pkg.sv
// dca_matrix_register_banked_pkg: op codes and matrix layout helpers shared by DCA matrix blocks.
// Rev 1.0
`default_nettype none

package dca_matrix_register_banked_pkg;

  typedef enum logic [2:0] {
    OP_NOP        = 3'd0,
    OP_SHIFT_UP   = 3'd1,
    OP_SHIFT_LEFT = 3'd2,
    OP_TRANSPOSE  = 3'd3,
    OP_SWAP       = 3'd4,
    OP_CLEAR      = 3'd5
  } op_e;

  function automatic int bw_row(input int ncols, input int bw);
    return ncols * bw;
  endfunction

  function automatic int bw_matrix(input int nrows, input int ncols, input int bw);
    return nrows * ncols * bw;
  endfunction

  function automatic int row_ofs(input int r, input int ncols, input int bw);
    return r * ncols * bw;
  endfunction

  function automatic int col_ofs(input int c, input int bw);
    return c * bw;
  endfunction

  // Element (r,c) sits at bit offset (r*ncols+c)*bw in the flattened matrix.
  function automatic int elem_ofs(input int r, input int c, input int ncols, input int bw);
    return row_ofs(r, ncols, bw) + col_ofs(c, bw);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dca_matrix_register_banked_if.sv
// dca_matrix_register_banked_if: load, op, store and readout signals of the banked matrix register.
// Rev 1.0
`default_nettype none

interface dca_matrix_register_banked_if #(
  parameter int BW_ROW    = 256,
  parameter int BW_MATRIX = 2048
);
  logic                 load_valid;
  logic                 load_ready;
  logic [BW_ROW-1:0]    load_row;
  logic                 shadow_full;
  logic                 op_valid;
  logic [2:0]           op_code;
  logic                 op_ready;
  logic                 op_error;
  logic                 store_start;
  logic                 store_valid;
  logic                 store_ready;
  logic [BW_ROW-1:0]    store_row;
  logic                 store_last;
  logic                 store_busy;
  logic [BW_MATRIX-1:0] all_rdata_list2d;
  logic [BW_ROW-1:0]    upmost_rdata_list1d;

  modport master (
    output load_valid, load_row, op_valid, op_code, store_start, store_ready,
    input  load_ready, shadow_full, op_ready, op_error, store_valid, store_row,
           store_last, store_busy, all_rdata_list2d, upmost_rdata_list1d
  );

  modport slave (
    input  load_valid, load_row, op_valid, op_code, store_start, store_ready,
    output load_ready, shadow_full, op_ready, op_error, store_valid, store_row,
           store_last, store_busy, all_rdata_list2d, upmost_rdata_list1d
  );
endinterface

`default_nettype wire

// File: rtl/dca_matrix_register_banked_bank.sv
// dca_matrix_bank: one matrix of storage with a row write port and in-place shift/transpose/clear.
// Rev 1.0
`default_nettype none

module dca_matrix_bank
  import dca_matrix_register_banked_pkg::*;
#(
  parameter int NUM_ROWS         = 8,
  parameter int NUM_COLS         = 8,
  parameter int BW_TENSOR_SCALAR = 32,
  parameter logic [BW_TENSOR_SCALAR-1:0] RESET_VALUE = '0,
  localparam int BW_ROW    = bw_row(NUM_COLS, BW_TENSOR_SCALAR),
  localparam int BW_MATRIX = bw_matrix(NUM_ROWS, NUM_COLS, BW_TENSOR_SCALAR),
  localparam int RIW       = $clog2(NUM_ROWS)
) (
  input  logic                 clk,
  input  logic                 rstp,
  input  logic                 wr_en,
  input  logic [RIW-1:0]       wr_idx,
  input  logic [BW_ROW-1:0]    wr_row,
  input  logic                 op_en,
  input  logic [2:0]           op_code,
  output logic [BW_MATRIX-1:0] data
);
  localparam int BW = BW_TENSOR_SCALAR;
  localparam logic [BW_ROW-1:0]    FILL_ROW    = {NUM_COLS{RESET_VALUE}};
  localparam logic [BW_MATRIX-1:0] FILL_MATRIX = {NUM_ROWS*NUM_COLS{RESET_VALUE}};

  logic [BW_MATRIX-1:0] mem;
  logic [BW_MATRIX-1:0] mem_nxt;
  logic [BW_MATRIX-1:0] transposed;

  // A non-square matrix has no in-place transpose; it passes through unchanged.
  if (NUM_ROWS == NUM_COLS) begin : g_transpose
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_r
      for (genvar c = 0; c < NUM_COLS; c++) begin : g_c
        assign transposed[elem_ofs(r, c, NUM_COLS, BW) +: BW] = mem[elem_ofs(c, r, NUM_COLS, BW) +: BW];
      end
    end
  end else begin : g_no_transpose
    assign transposed = mem;
  end

  always_comb begin
    mem_nxt = mem;
    if (wr_en) begin
      mem_nxt[row_ofs(int'(wr_idx), NUM_COLS, BW) +: BW_ROW] = wr_row;
    end
    if (op_en) begin
      case (op_code)
        OP_SHIFT_UP: begin
          for (int r = 0; r < NUM_ROWS - 1; r++) begin
            mem_nxt[row_ofs(r, NUM_COLS, BW) +: BW_ROW] = mem[row_ofs(r + 1, NUM_COLS, BW) +: BW_ROW];
          end
          mem_nxt[row_ofs(NUM_ROWS - 1, NUM_COLS, BW) +: BW_ROW] = FILL_ROW;
        end
        OP_SHIFT_LEFT: begin
          for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS - 1; c++) begin
              mem_nxt[elem_ofs(r, c, NUM_COLS, BW) +: BW] = mem[elem_ofs(r, c + 1, NUM_COLS, BW) +: BW];
            end
            mem_nxt[elem_ofs(r, NUM_COLS - 1, NUM_COLS, BW) +: BW] = RESET_VALUE;
          end
        end
        OP_TRANSPOSE: mem_nxt = transposed;
        OP_CLEAR:     mem_nxt = FILL_MATRIX;
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      mem <= FILL_MATRIX;
    end else begin
      mem <= mem_nxt;
    end
  end

  assign data = mem;

endmodule

`default_nettype wire

// File: rtl/dca_matrix_register_banked.sv
// dca_matrix_register_banked: ping-pong matrix register; loads fill the shadow bank while ops and stores use the active one.
// Rev 1.0
`default_nettype none

module dca_matrix_register_banked
  import dca_matrix_register_banked_pkg::*;
#(
  parameter int NUM_ROWS         = 8,
  parameter int NUM_COLS         = 8,
  parameter int BW_TENSOR_SCALAR = 32,
  parameter logic [BW_TENSOR_SCALAR-1:0] RESET_VALUE = '0
) (
  input logic                        clk,
  input logic                        rstp,
  dca_matrix_register_banked_if.slave bus
);
  localparam int BW_ROW    = bw_row(NUM_COLS, BW_TENSOR_SCALAR);
  localparam int BW_MATRIX = bw_matrix(NUM_ROWS, NUM_COLS, BW_TENSOR_SCALAR);
  localparam int RIW       = $clog2(NUM_ROWS);
  localparam logic [RIW-1:0] LAST_ROW = RIW'(NUM_ROWS - 1);
  localparam logic SQUARE = (NUM_ROWS == NUM_COLS);

  localparam logic [0:0] LD_FILL   = 1'b0;
  localparam logic [0:0] LD_FULL   = 1'b1;
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  logic                 active_idx;
  logic [0:0]           load_state;
  logic [0:0]           store_state;
  logic [RIW-1:0]       load_cnt;
  logic [RIW-1:0]       store_ptr;
  logic                 op_error_q;
  logic                 load_fire;
  logic                 op_fire;
  logic                 op_ready_w;
  logic                 op_bad;
  logic [BW_MATRIX-1:0] bank_data [2];
  logic [BW_MATRIX-1:0] active_data;

  assign load_fire  = bus.load_valid && (load_state == LD_FILL);
  assign op_ready_w = (store_state == ST_IDLE) && !(bus.op_code == OP_SWAP && load_state != LD_FULL)
                      && !bus.store_start;
  assign op_fire    = bus.op_valid && op_ready_w;
  assign op_bad     = (bus.op_code > OP_CLEAR) || (bus.op_code == OP_TRANSPOSE && !SQUARE);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    dca_matrix_bank #(
      .NUM_ROWS        (NUM_ROWS),
      .NUM_COLS        (NUM_COLS),
      .BW_TENSOR_SCALAR(BW_TENSOR_SCALAR),
      .RESET_VALUE     (RESET_VALUE)
    ) u_bank (
      .clk    (clk),
      .rstp   (rstp),
      .wr_en  (load_fire && (active_idx != 1'(b))),
      .wr_idx (load_cnt),
      .wr_row (bus.load_row),
      .op_en  (op_fire && (active_idx == 1'(b))),
      .op_code(bus.op_code),
      .data   (bank_data[b])
    );
  end

  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      active_idx <= 1'b0;
      load_state <= LD_FILL;
      load_cnt   <= '0;
      op_error_q <= 1'b0;
    end else begin
      op_error_q <= op_fire && op_bad;
      if (load_fire) begin
        if (load_cnt == LAST_ROW) begin
          load_cnt   <= '0;
          load_state <= LD_FULL;
        end else begin
          load_cnt <= load_cnt + 1'b1;
        end
      end
      // SWAP is only accepted when FULL, so it never races a load beat.
      if (op_fire && bus.op_code == OP_SWAP) begin
        active_idx <= ~active_idx;
        load_state <= LD_FILL;
      end
    end
  end

  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      store_state <= ST_IDLE;
      store_ptr   <= '0;
    end else if (store_state == ST_IDLE) begin
      if (bus.store_start) begin
        store_state <= ST_STREAM;
        store_ptr   <= '0;
      end
    end else if (bus.store_ready) begin
      if (store_ptr == LAST_ROW) begin
        store_state <= ST_IDLE;
        store_ptr   <= '0;
      end else begin
        store_ptr <= store_ptr + 1'b1;
      end
    end
  end

  assign active_data             = active_idx ? bank_data[1] : bank_data[0];
  assign bus.load_ready          = (load_state == LD_FILL);
  assign bus.shadow_full         = (load_state == LD_FULL);
  assign bus.op_ready            = op_ready_w;
  assign bus.op_error            = op_error_q;
  assign bus.store_valid         = (store_state == ST_STREAM);
  assign bus.store_busy          = (store_state == ST_STREAM);
  assign bus.store_last          = (store_state == ST_STREAM) && (store_ptr == LAST_ROW);
  assign bus.store_row           = active_data[row_ofs(int'(store_ptr), NUM_COLS, BW_TENSOR_SCALAR) +: BW_ROW];
  assign bus.all_rdata_list2d    = active_data;
  assign bus.upmost_rdata_list1d = active_data[BW_ROW-1:0];

endmodule

`default_nettype wire
